// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU ops, opcodes,
// funct codes, FSM states and the per-state datapath control bundle.
package mips_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_NOT = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_NOT = 6'h27;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_cnt;
    } ctl_t;

endpackage

// File: rtl/mips_multicycle_control_alu_control.sv
// R-type funct -> ALU operation decoder; unknown funct yields ADD with
// funct_valid low so the FSM can skip the writeback.
module alu_control
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_cnt,
    output logic       funct_valid
);

    always_comb begin
        alu_cnt     = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_cnt = ALU_ADD;
            FN_SUB:  alu_cnt = ALU_SUB;
            FN_NOT:  alu_cnt = ALU_NOT;
            FN_SLL:  alu_cnt = ALU_SLL;
            FN_SRL:  alu_cnt = ALU_SRL;
            FN_AND:  alu_cnt = ALU_AND;
            FN_OR:   alu_cnt = ALU_OR;
            FN_SLT:  alu_cnt = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: Moore datapath controls per state, with
// funct-driven ALU select in EXEC and zero-qualified PC load in BRANCH.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_cnt,
    output logic [3:0] state_dbg
);

    state_t     state, state_nxt;
    ctl_t       c;
    logic [3:0] fn_alu;
    logic       fn_ok;

    alu_control u_alu_control (
        .funct      (funct),
        .alu_cnt    (fn_alu),
        .funct_valid(fn_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        c         = '0;
        case (state)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
                state_nxt   = S_DECODE;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                state_nxt   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
                state_nxt  = S_MEMWB;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_cnt   = fn_alu;
                // unknown funct: no writeback, go straight back to fetch
                state_nxt   = fn_ok ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_cnt   = ALU_SUB;
                c.branch    = 1'b1;
                c.pc_source = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                state_nxt   = S_ADDIWB;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            default:  state_nxt = S_FETCH;
        endcase

        // reset presents FETCH selects with every write/strobe suppressed
        if (reset) begin
            c           = '0;
            c.alu_src_b = 2'b01;
        end
    end

    assign pc_en      = c.pc_write | (c.branch & zero);
    assign iord       = c.iord;
    assign mem_read   = c.mem_read;
    assign mem_write  = c.mem_write;
    assign ir_write   = c.ir_write;
    assign mem_to_reg = c.mem_to_reg;
    assign reg_dst    = c.reg_dst;
    assign reg_write  = c.reg_write;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign pc_source  = c.pc_source;
    assign alu_cnt    = c.alu_cnt;
    assign state_dbg  = reset ? S_FETCH : state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: per-instruction phase sequences from the ISA rules,
// random instruction mix with random mid-instruction resets.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_cnt, state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // phase ids equal the documented state numbers; -1 marks a reset cycle
    localparam int PH_RST = -1, PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4,
                   PH_MW = 5, PH_EX = 6, PH_AWB = 7, PH_BR = 8, PH_J = 9, PH_AE = 10,
                   PH_AW = 11;

    int seq[$];

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_cnt(alu_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int fn_op(input logic [5:0] fn);
        case (fn)
            6'h20: return 0;
            6'h22: return 1;
            6'h27: return 2;
            6'h00: return 3;
            6'h02: return 4;
            6'h24: return 5;
            6'h25: return 6;
            6'h2A: return 7;
            default: return -1;
        endcase
    endfunction

    // instruction class -> ordered list of phases it walks through
    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
        seq = '{PH_F, PH_D};
        case (op)
            6'h23: seq = {seq, PH_MA, PH_MR, PH_MWB};
            6'h2B: seq = {seq, PH_MA, PH_MW};
            6'h00: begin
                seq.push_back(PH_EX);
                if (fn_op(fn) >= 0) seq.push_back(PH_AWB);
            end
            6'h04: seq.push_back(PH_BR);
            6'h02: seq.push_back(PH_J);
            6'h08: seq = {seq, PH_AE, PH_AW};
            default: ;
        endcase
    endtask

    // {pc_en,iord,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,
    //  alu_src_a,alu_src_b,pc_source,alu_cnt}
    function automatic logic [16:0] exp_ctl(input int ph, input logic [5:0] fn, input logic z);
        logic pe, io, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        {pe, io, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ac} = '0;
        case (ph)
            PH_RST: sb = 2'b01;
            PH_F:   begin mr = 1; irw = 1; pe = 1; sb = 2'b01; end
            PH_D:   sb = 2'b11;
            PH_MA:  begin sa = 1; sb = 2'b10; end
            PH_MR:  begin io = 1; mr = 1; end
            PH_MWB: begin rw = 1; m2r = 1; end
            PH_MW:  begin io = 1; mw = 1; end
            PH_EX:  begin sa = 1; ac = (fn_op(fn) >= 0) ? 4'(fn_op(fn)) : 4'd0; end
            PH_AWB: begin rw = 1; rd = 1; end
            PH_BR:  begin sa = 1; ac = 4'd1; ps = 2'b01; pe = z; end
            PH_J:   begin pe = 1; ps = 2'b10; end
            PH_AE:  begin sa = 1; sb = 2'b10; end
            PH_AW:  rw = 1;
            default: ;
        endcase
        return {pe, io, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ac};
    endfunction

    function automatic logic [16:0] obs_ctl();
        return {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, pc_source, alu_cnt};
    endfunction

    // abort_at: phase index at which reset is raised for one cycle (-1 = never)
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int abort_at);
        int ph;
        build_seq(op, fn);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < seq.size(); i++) begin
            ph    = seq[i];
            zero  = (ph == PH_BR) ? z : 1'($urandom);
            if (i == abort_at) begin
                reset = 1'b1;
                ph    = PH_RST;
            end
            @(negedge clk);
            chk($sformatf("ctl op=%h fn=%h ph=%0d", op, fn, ph), 32'(obs_ctl()),
                32'(exp_ctl(ph, fn, zero)));
            chk($sformatf("state op=%h ph=%0d", op, ph), 32'(state_dbg),
                32'((ph == PH_RST) ? 0 : ph));
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[8];
        logic [5:0] op, fn;
        int ab;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        fns = '{6'h20, 6'h22, 6'h27, 6'h00, 6'h02, 6'h24, 6'h25, 6'h2A};

        reset  = 1'b1;
        opcode = 6'h23;
        funct  = 6'h20;
        zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset ctl", 32'(obs_ctl()), 32'(exp_ctl(PH_RST, 6'h20, 1'b0)));
            chk("reset state", 32'(state_dbg), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr(6'h23, 6'h20, 1'b0, -1);
        for (int i = 0; i < 8; i++) run_instr(6'h00, fns[i], 1'b0, -1);
        run_instr(6'h04, 6'h20, 1'b1, -1);
        run_instr(6'h04, 6'h20, 1'b0, -1);
        run_instr(6'h2B, 6'h20, 1'b0, -1);
        run_instr(6'h02, 6'h20, 1'b0, -1);
        run_instr(6'h08, 6'h20, 1'b0, -1);
        run_instr(6'h3F, 6'h20, 1'b0, -1);
        run_instr(6'h00, 6'h3F, 1'b0, -1);
        run_instr(6'h2B, 6'h20, 1'b0, 3);   // reset while in MEMWR
        run_instr(6'h00, 6'h25, 1'b0, 3);   // reset while in ALUWB
        run_instr(6'h23, 6'h20, 1'b0, -1);

        for (int n = 0; n < 400; n++) begin
            int k;
            k  = $urandom_range(0, 6);
            op = (k == 6) ? 6'($urandom) : ops[k];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(op, fn, 1'($urandom), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; the driving end of the ALU's 4-bit operation-select interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Emits datapath enables and mux selects every cycle.
- Translates opcode/funct into the ALU operation code, so the ALU itself stays purely combinational.

Parameters:
- None. The block is fixed to MIPS-32 opcode and funct widths; encodings live in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (1 when result == 0)
- pc_en  out  1  PC load = pc_write | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pc_source  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_cnt  out  4  ALU operation select
- state_dbg  out  4  current state encoding

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Outputs are Moore, decoded combinationally from the state register. The only exceptions are alu_cnt in EXEC (a function of funct) and pc_en (a function of zero).
- ALU encodings: ADD=0, SUB=1, NOT=2, SLL=3, SRL=4, AND=5, OR=6, SLT=7. Values 8-15 are never driven.
- States:
  - FETCH: mem_read, ir_write, pc_write; alu_src_a=0, alu_src_b=01, ADD, pc_source=00.
  - DECODE: alu_src_a=0, alu_src_b=11, ADD (precomputes branch target).
  - MEMADR: alu_src_a=1, alu_src_b=10, ADD.
  - MEMRD: iord=1, mem_read.
  - MEMWB: reg_write, mem_to_reg=1, reg_dst=0.
  - MEMWR: iord=1, mem_write.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_cnt from funct.
  - ALUWB: reg_write, reg_dst=1, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, branch=1, pc_source=01.
  - JUMP: pc_write, pc_source=10.
  - ADDIEX: alu_src_a=1, alu_src_b=10, ADD.
  - ADDIWB: reg_write, reg_dst=0, mem_to_reg=0.
- Any signal not listed for a state is 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by opcode: 0x23 (lw) / 0x2B (sw) -> MEMADR; 0x00 -> EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDIEX; any other opcode -> FETCH (illegal instruction skipped, no writes).
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB.
  - EXEC -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB -> FETCH.
- Cycle counts: lw 5; sw, R-type, addi 4; beq, j 3; illegal opcode 2.
- R-type funct map: 0x20 ADD, 0x22 SUB, 0x27 NOT, 0x00 SLL, 0x02 SRL, 0x24 AND, 0x25 OR, 0x2A SLT.
- Unknown funct: alu_cnt=ADD in EXEC, then EXEC -> FETCH, skipping ALUWB so nothing is written.
- pc_en in BRANCH is 1 only when zero=1. pc_en is never asserted outside FETCH, JUMP, and taken BRANCH.
- Reset:
  - A clock edge with reset=1 forces the state to FETCH from any state, including mid-instruction. An in-flight store or writeback is abandoned.
  - While reset=1, pc_en, ir_write, mem_read, mem_write and reg_write are forced to 0. All other outputs take their FETCH values.
  - The first fetch occurs on the first cycle with reset=0.
- Simultaneous events: reset has priority over every transition. zero is sampled only in BRANCH.
- State encoding: 4-bit binary, FETCH=0 … ADDIWB=11. Illegal codes 12-15 -> FETCH next cycle with all enables 0.

Decomposition:
- Package mips_pkg holds:
  - ALU op localparams (ALU_ADD … ALU_SLT)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - funct constants
  - state encodings
- One natural sub-module: alu_control, a combinational funct -> alu_cnt decoder that also outputs funct_valid. The FSM muxes its output in only during EXEC.

Test Plan:
- reset held 3 cycles, then released with opcode=0x23 -> during reset all enables 0; then FETCH, DECODE, MEMADR, MEMRD, MEMWB, with reg_write=1 and mem_to_reg=1 only in cycle 5; back in FETCH at cycle 6.
- opcode=0x00 with each funct in {0x20, 0x22, 0x27, 0x00, 0x02, 0x24, 0x25, 0x2A} -> alu_cnt in EXEC = 0, 1, 2, 3, 4, 5, 6, 7 respectively; ALUWB has reg_dst=1.
- opcode=0x04 with zero=1 -> pc_en=1 and pc_source=01 in BRANCH. Repeat with zero=0 -> pc_en=0. Either case returns to FETCH.
- opcode=0x2B -> mem_write=1 exactly once (MEMWR, iord=1) and reg_write never 1; 4 cycles total.
- opcode=0x3F (illegal), then opcode=0x00 with funct=0x3F -> the first returns to FETCH after DECODE; the second reaches EXEC with alu_cnt=0 and returns to FETCH without reg_write.
- reset asserted in MEMWR and in ALUWB -> the next state is FETCH, mem_write and reg_write are 0 on that cycle, and state_dbg=0.
